// File: rtl/cos_lut_sched.sv
// rtl/cos_lut_sched.sv - cosine LUT address sequencer for one DFT bin
module cos_lut_sched #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 18,
   parameter int NLOG2  = 10
) (
   input  logic                     Clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        k,
   input  logic                     abort,
   output logic                     busy,
   output logic                     done,
   output logic [ADDR_W-1:0]        lut_addr,
   input  logic signed [DATA_W-1:0] lut_dout,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_cos,
   output logic signed [DATA_W-1:0] out_sin,
   output logic [NLOG2-1:0]         out_n,
   output logic                     out_last
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_COS   = 3'd1;
   localparam logic [2:0] S_SIN   = 3'd2;
   localparam logic [2:0] S_PAIR  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   // A quarter period: sin(x) is read as cos(x - quarter).
   localparam logic [ADDR_W-1:0] QUARTER = {2'b01, {(ADDR_W-2){1'b0}}};
   localparam logic [NLOG2-1:0]  N_MAX   = '1;

   logic [2:0]               state;
   logic [ADDR_W-1:0]        k_q;
   logic [ADDR_W-1:0]        phase;
   logic [NLOG2-1:0]         n;
   logic signed [DATA_W-1:0] cos_q;
   logic                     handshake;
   logic                     can_load;

   assign handshake = out_valid && out_ready;
   assign can_load  = !out_valid || out_ready;

   // LUT address follows the state; PAIR keeps the sine address so a stalled
   // pair keeps re-reading the same sine value.
   always_comb begin
      lut_addr = '0;
      case (state)
         S_COS:          lut_addr = phase;
         S_SIN, S_PAIR:  lut_addr = phase - QUARTER;
         default:        lut_addr = '0;
      endcase
   end

   // Sequencer state, phase accumulator and output triple register.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         k_q       <= '0;
         phase     <= '0;
         n         <= '0;
         cos_q     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_cos   <= '0;
         out_sin   <= '0;
         out_n     <= '0;
         out_last  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
         end else begin
            if (handshake) begin
               out_valid <= 1'b0;
            end
            case (state)
               S_IDLE: begin
                  if (start) begin
                     k_q   <= k;
                     phase <= '0;
                     n     <= '0;
                     busy  <= 1'b1;
                     state <= S_COS;
                  end
               end
               S_COS: begin
                  state <= S_SIN;
               end
               S_SIN: begin
                  cos_q <= lut_dout;
                  state <= S_PAIR;
               end
               S_PAIR: begin
                  if (can_load) begin
                     out_cos   <= cos_q;
                     out_sin   <= lut_dout;
                     out_n     <= n;
                     out_last  <= (n == N_MAX);
                     out_valid <= 1'b1;
                     phase     <= phase + k_q;
                     n         <= n + 1'b1;
                     state     <= (n == N_MAX) ? S_DRAIN : S_COS;
                  end
               end
               S_DRAIN: begin
                  if (handshake) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
